// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty scheduler in front of the pwm block: walks duty_out
// toward a commanded target in STEP increments, one step per PERIODS_PER_STEP PWM periods.
module pwm_ramp_ctrl #(
  parameter int PWM_FREQ         = 25000,
  parameter int CLK_FREQ         = 500000,
  parameter int MAX_COUNT        = (CLK_FREQ/PWM_FREQ)-1,
  parameter int STEP             = 4,
  parameter int PERIODS_PER_STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_duty,
  output logic       cmd_ready,
  input  logic       estop,
  output logic [7:0] duty_out,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] PCNT_LAST = 16'(MAX_COUNT);
  localparam logic [15:0] SCNT_LAST = 16'(PERIODS_PER_STEP - 1);
  localparam logic [8:0]  STEP9     = 9'(STEP);
  localparam logic [7:0]  STEP8     = 8'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

  state_t      state;
  logic [7:0]  target;
  logic [15:0] pcnt;
  logic [15:0] scnt;
  logic        period_end;
  logic        step_tick;
  logic        accept;
  logic        up;
  logic [8:0]  diff;

  assign period_end = (pcnt == PCNT_LAST);
  assign step_tick  = period_end && (scnt == SCNT_LAST);
  assign cmd_ready  = (state == IDLE) && !estop && rst;
  assign accept     = cmd_valid && cmd_ready;

  // Distance to target in 9 bits so a full 0<->255 swing never overflows.
  assign up   = (target > duty_out);
  assign diff = up ? ({1'b0, target} - {1'b0, duty_out})
                   : ({1'b0, duty_out} - {1'b0, target});

  // Timebase mirrors the pwm period; it keeps running through commands and estop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      scnt <= '0;
    end else begin
      pcnt <= period_end ? '0 : pcnt + 16'd1;
      if (period_end)
        scnt <= (scnt == SCNT_LAST) ? '0 : scnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      target   <= '0;
      duty_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (estop) begin
      state    <= IDLE;
      target   <= '0;
      duty_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target <= cmd_duty;
            busy   <= 1'b1;
            if (cmd_duty == duty_out) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (step_tick) begin
            if (diff <= STEP9) begin
              duty_out <= target;
              state    <= DONE;
              done     <= 1'b1;
            end else begin
              duty_out <= up ? duty_out + STEP8 : duty_out - STEP8;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: stimulus queues expected duty/done events,
// an independent monitor pops them whenever duty_out moves or done pulses.
module tb_pwm_ramp_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_duty;
  logic       cmd_ready;
  logic       estop;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;

  pwm_ramp_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_duty  (cmd_duty),
    .cmd_ready (cmd_ready),
    .estop     (estop),
    .duty_out  (duty_out),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [7:0] duty;
    logic       done;
    logic       busy;
    int         gap;   // cycles since previous event, -1 = not checked
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  int  last_cyc = 0;
  logic [7:0] prev_duty = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: every duty change or done pulse must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    cyc++;
    if (rst && ((duty_out !== prev_duty) || done)) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got duty=%0d done=%0b busy=%0b, required no event",
                 duty_out, done, busy);
      end else begin
        e = exp_q.pop_front();
        if (duty_out !== e.duty || done !== e.done || busy !== e.busy ||
            (e.gap >= 0 && (cyc - last_cyc) != e.gap)) begin
          n_fail++;
          $display("FAIL sb_event: got duty=%0d done=%0b busy=%0b gap=%0d, required duty=%0d done=%0b busy=%0b gap=%0d",
                   duty_out, done, busy, cyc - last_cyc, e.duty, e.done, e.busy, e.gap);
        end
      end
      last_cyc = cyc;
    end
    prev_duty = duty_out;
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int d, input bit dn, input bit b, input int gap);
    ev_t e;
    e.duty = 8'(d); e.done = dn; e.busy = b; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Expected step sequence from -> to, truncated to nmax events.
  task automatic push_ramp(input int from, input int to, input int nmax);
    int cur, d, n;
    cur = from; n = 0;
    while (cur != to && n < nmax) begin
      d = (to > cur) ? to - cur : cur - to;
      if (d <= 4) cur = to;
      else        cur = (to > cur) ? cur + 4 : cur - 4;
      push(cur, cur == to, 1'b1, (n == 0) ? -1 : 40);
      n++;
    end
  endtask

  task automatic send(input logic [7:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("send_ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Wait for done, then require a single-cycle pulse and busy dropping.
  task automatic wait_done(input int bound, input int final_duty);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", int'(done), 1);
    chk("done_duty", int'(duty_out), final_duty);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_falls", int'(busy), 0);
    chk("duty_hold", int'(duty_out), final_duty);
  endtask

  task automatic wait_duty(input int d, input int bound);
    int k;
    k = 0;
    @(negedge clk);
    while (duty_out != 8'(d) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("wait_duty_reached", int'(duty_out), d);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b1; cmd_duty = 8'd200; estop = 1'b0;

    // Reset holds everything quiet even with a command offered.
    repeat (5) begin
      @(negedge clk);
      chk("rst_duty", int'(duty_out), 0);
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
    end
    rst = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

    // Ramp up 0 -> 10: 4, 8, 10 one step period apart.
    push(4, 0, 1, -1); push(8, 0, 1, 40); push(10, 1, 1, 40);
    send(8'd10);
    wait_done(200, 10);

    // Ramp to 100 while a competing command is refused.
    push_ramp(10, 100, 999);
    send(8'd100);
    cmd_valid = 1'b1; cmd_duty = 8'd20;
    repeat (60) begin
      @(negedge clk);
      chk("ready_low_in_ramp", int'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    wait_done(2000, 100);

    // Equal-duty command: done on the next cycle, no step.
    push(100, 1, 1, -1);
    send(8'd100);
    @(negedge clk);
    chk("equal_done", int'(done), 1);
    chk("equal_duty", int'(duty_out), 100);
    @(negedge clk);
    chk("equal_done_clear", int'(done), 0);
    chk("equal_busy_clear", int'(busy), 0);

    // Up to 255, then down to 250 with a 1-count residue.
    push_ramp(100, 255, 999);
    send(8'd255);
    wait_done(2000, 255);
    push(251, 0, 1, -1); push(250, 1, 1, 40);
    send(8'd250);
    wait_done(200, 250);

    // Short estop in IDLE to return to zero.
    push(0, 0, 0, -1);
    @(negedge clk) estop = 1'b1;
    @(negedge clk) estop = 1'b0;
    @(negedge clk);
    chk("estop_idle_zero", int'(duty_out), 0);

    // Estop mid-ramp at duty 48.
    push_ramp(0, 200, 12);
    send(8'd200);
    wait_duty(48, 1000);
    push(0, 0, 0, -1);
    estop = 1'b1;
    #1 chk("estop_ready_comb", int'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_duty = 8'd77;
    repeat (10) begin
      @(negedge clk);
      chk("estop_duty", int'(duty_out), 0);
      chk("estop_busy", int'(busy), 0);
      chk("estop_done", int'(done), 0);
      chk("estop_ready", int'(cmd_ready), 0);
    end
    estop = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_estop_ready", int'(cmd_ready), 1);
    chk("post_estop_duty", int'(duty_out), 0);
    push(4, 0, 1, -1); push(8, 1, 1, 40);
    send(8'd8);
    wait_done(200, 8);

    // Asynchronous reset pulse mid-ramp at duty 120, away from any clock edge.
    push_ramp(8, 200, 28);
    send(8'd200);
    wait_duty(120, 2000);
    push(0, 0, 0, -1);
    #2 rst = 1'b0;
    #1;
    chk("arst_duty", int'(duty_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_ready", int'(cmd_ready), 0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("arst_idle_ready", int'(cmd_ready), 1);
    chk("arst_idle_busy", int'(busy), 0);
    repeat (50) @(negedge clk);
    chk("arst_no_done", int'(done), 0);
    chk("arst_duty_stays", int'(duty_out), 0);

    chk("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
